// File: rtl/key_pkg.sv
// Shared types and constants for the key conditioning front end.
package key_pkg;

   typedef enum logic [1:0] {
      IDLE_LOW  = 2'd0,
      WAIT_HIGH = 2'd1,
      HELD_HIGH = 2'd2,
      WAIT_LOW  = 2'd3
   } key_state_t;

   localparam int unsigned KEY_NOTE0   = 0;
   localparam int unsigned KEY_NOTE1   = 1;
   localparam int unsigned KEY_NOTE2   = 2;
   localparam int unsigned KEY_NOTE3   = 3;
   localparam int unsigned KEY_NOTE4   = 4;
   localparam int unsigned KEY_NOTE5   = 5;
   localparam int unsigned KEY_NOTE6   = 6;
   localparam int unsigned KEY_OCT_UP  = 7;
   localparam int unsigned KEY_OCT_DN  = 8;
   localparam int unsigned KEY_CONFIRM = 9;
   localparam int unsigned KEY_NEXT    = 10;
   localparam int unsigned KEY_PREV    = 11;

   localparam int unsigned NUM_KEYS_DEFAULT        = 12;
   localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 2000000;
   localparam int unsigned REPEAT_DELAY_DEFAULT    = 50000000;
   localparam int unsigned REPEAT_PERIOD_DEFAULT   = 10000000;

endpackage

// File: rtl/key_debounce_cell.sv
// One key: 2-flop synchroniser, debounce FSM with stable-time counter, press/release pulses.
// Optional auto-repeat on a held key when KEY_AUTOREPEAT_EN is defined.
module key_debounce_cell
   import key_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
   parameter int unsigned REPEAT_DELAY    = REPEAT_DELAY_DEFAULT,
   parameter int unsigned REPEAT_PERIOD   = REPEAT_PERIOD_DEFAULT
) (
   input  logic clk,
   input  logic reset,
   input  logic raw_key,
   output logic key_level,
   output logic key_press,
   output logic key_release
);

   localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES) + 1;
   localparam logic [CW-1:0] CNT_TERM = CW'(DEBOUNCE_CYCLES - 1);

   logic meta_q, sync_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= raw_key;
         sync_q <= meta_q;
      end
   end

   key_state_t state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic level_q, level_d;
   logic press_q, press_d;
   logic rel_q, rel_d;
   logic rep_fire;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      level_d = level_q;
      press_d = 1'b0;
      rel_d   = 1'b0;
      unique case (state_q)
         IDLE_LOW: begin
            if (sync_q) begin
               state_d = WAIT_HIGH;
               cnt_d   = CW'(1);
            end
         end
         WAIT_HIGH: begin
            if (!sync_q) begin
               state_d = IDLE_LOW;
               cnt_d   = '0;
            end else if (cnt_q == CNT_TERM) begin
               state_d = HELD_HIGH;
               cnt_d   = '0;
               level_d = 1'b1;
               press_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         HELD_HIGH: begin
            if (!sync_q) begin
               state_d = WAIT_LOW;
               cnt_d   = CW'(1);
            end
         end
         WAIT_LOW: begin
            if (sync_q) begin
               state_d = HELD_HIGH;
               cnt_d   = '0;
            end else if (cnt_q == CNT_TERM) begin
               state_d = IDLE_LOW;
               cnt_d   = '0;
               level_d = 1'b0;
               rel_d   = 1'b1;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: begin
            state_d = IDLE_LOW;
            cnt_d   = '0;
         end
      endcase
   end

`ifdef KEY_AUTOREPEAT_EN
   localparam int unsigned RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int unsigned RW = $clog2(RMAX) + 1;

   logic [RW-1:0] rep_q, rep_d;
   logic armed_q, armed_d;  // first repeat already issued; later ones use REPEAT_PERIOD

   always_comb begin
      rep_d    = '0;
      armed_d  = 1'b0;
      rep_fire = 1'b0;
      // Counting only while the key stays in HELD_HIGH; any exit clears the counter.
      if (state_q == HELD_HIGH && state_d == HELD_HIGH) begin
         rep_d   = rep_q + RW'(1);
         armed_d = armed_q;
         if (armed_q ? (rep_q == RW'(REPEAT_PERIOD - 1)) : (rep_q == RW'(REPEAT_DELAY - 1))) begin
            rep_fire = 1'b1;
            rep_d    = '0;
            armed_d  = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rep_q   <= '0;
         armed_q <= 1'b0;
      end else begin
         rep_q   <= rep_d;
         armed_q <= armed_d;
      end
   end
`else
   assign rep_fire = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE_LOW;
         cnt_q   <= '0;
         level_q <= 1'b0;
         press_q <= 1'b0;
         rel_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         level_q <= level_d;
         press_q <= press_d | rep_fire;
         rel_q   <= rel_d;
      end
   end

   assign key_level   = level_q;
   assign key_press   = press_q;
   assign key_release = rel_q;

endmodule

// File: rtl/key_conditioner.sv
// Debounces NUM_KEYS raw pins into clean levels and press/release pulses.
// Optional auto-repeat of key_press via the KEY_AUTOREPEAT_EN macro.
module key_conditioner
   import key_pkg::*;
#(
   parameter int unsigned NUM_KEYS        = NUM_KEYS_DEFAULT,
   parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
   parameter int unsigned REPEAT_DELAY    = REPEAT_DELAY_DEFAULT,
   parameter int unsigned REPEAT_PERIOD   = REPEAT_PERIOD_DEFAULT
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [NUM_KEYS-1:0] raw_keys,
   output logic [NUM_KEYS-1:0] key_level,
   output logic [NUM_KEYS-1:0] key_press,
   output logic [NUM_KEYS-1:0] key_release,
   output logic                any_level
);

   for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
      key_debounce_cell #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .REPEAT_DELAY    (REPEAT_DELAY),
         .REPEAT_PERIOD   (REPEAT_PERIOD)
      ) u_cell (
         .clk         (clk),
         .reset       (reset),
         .raw_key     (raw_keys[k]),
         .key_level   (key_level[k]),
         .key_press   (key_press[k]),
         .key_release (key_release[k])
      );
   end

   logic any_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         any_q <= 1'b0;
      end else begin
         any_q <= |key_level;
      end
   end

   assign any_level = any_q;

endmodule

// File: doc/key_conditioner.md
Name: key_conditioner

Overview:
- Front-end conditioning stage between the board pins (keys, octave keys, confirm/next/prev buttons) and the top-level mode/controller logic.
- Per key: synchronises the raw input, debounces it with a stable-time counter, and produces a clean level plus one-cycle press and release pulses.
- Downstream controllers consume the levels (note keys) and the press pulses (song select, confirm) instead of raw pins.

Parameters:
- NUM_KEYS, 12: number of independent inputs (7 note keys, 2 octave keys, confirm, next, prev).
- DEBOUNCE_CYCLES, 2000000: cycles a new input value must hold before it is accepted (20 ms at 100 MHz). Minimum 2.
- REPEAT_DELAY, 50000000: hold cycles before the first auto-repeat pulse. Used only with the optional feature.
- REPEAT_PERIOD, 10000000: cycles between later auto-repeat pulses. Used only with the optional feature.

Ports:
- clk, input, 1: system clock.
- reset, input, 1: synchronous, active-high reset.
- raw_keys, input, NUM_KEYS: asynchronous raw pin levels, active-high.
- key_level, output, NUM_KEYS: debounced level.
- key_press, output, NUM_KEYS: one-cycle pulse on accepted 0->1 transition (and on repeats when enabled).
- key_release, output, NUM_KEYS: one-cycle pulse on accepted 1->0 transition.
- any_level, output, 1: OR of key_level, registered.

Behaviour:
- Reset (synchronous, reset=1 at posedge):
  - all outputs, synchroniser flops, counters and FSMs go to 0 / IDLE_LOW;
  - a key held during reset is reported as a fresh press once debounced after reset is released.
- Synchroniser: 2 flops per key; sync = second flop. No logic between the two flops.
- Per-key FSM states: IDLE_LOW, WAIT_HIGH, HELD_HIGH, WAIT_LOW.
  - IDLE_LOW:
    - sync=1: go to WAIT_HIGH, counter=1.
  - WAIT_HIGH:
    - sync=0: back to IDLE_LOW, counter=0 (glitch rejected, no pulse).
    - sync=1 and counter==DEBOUNCE_CYCLES-1: go to HELD_HIGH; key_level=1 and key_press=1 on the same clock edge.
    - otherwise: counter+1.
  - HELD_HIGH:
    - sync=0: go to WAIT_LOW, counter=1.
  - WAIT_LOW: mirror of WAIT_HIGH.
    - acceptance: key_level=0 and key_release=1 together;
    - bounce back to 1: return to HELD_HIGH with no pulse.
- Latency: a clean edge on raw_keys appears at key_level exactly 2 + DEBOUNCE_CYCLES cycles later.
- key_press and key_release:
  - each high for exactly one cycle per accepted edge;
  - never both high for the same key in the same cycle.
- Counter width: clog2(DEBOUNCE_CYCLES)+1 bits. It never wraps, because every WAIT state exits at the terminal count.
- Keys are fully independent. Simultaneous edges on several keys give simultaneous pulses.
- any_level is key_level ORed and registered: 1 cycle behind key_level.
- Reset mid-debounce discards the partial count; no pulse is emitted.

Optional Feature:
- Macro: KEY_AUTOREPEAT_EN.
- Defined:
  - each key gets a repeat counter that starts on entry to HELD_HIGH;
  - after REPEAT_DELAY cycles of continuous HELD_HIGH, key_press pulses once, then again every REPEAT_PERIOD cycles;
  - the counter is cleared on leaving HELD_HIGH, including entry to WAIT_LOW even if the key bounces back;
  - key_release is unaffected.
- Not defined: no repeat logic or counters exist; key_press fires only on accepted rising edges.

Decomposition:
- Shared package key_pkg holds:
  - FSM state typedef key_state_t (IDLE_LOW, WAIT_HIGH, HELD_HIGH, WAIT_LOW);
  - key-index constants KEY_NOTE0..KEY_NOTE6, KEY_OCT_UP, KEY_OCT_DN, KEY_CONFIRM, KEY_NEXT, KEY_PREV;
  - default debounce and repeat cycle constants.
- Sub-module key_debounce_cell:
  - contents: one key's synchroniser, FSM, counter and optional repeat logic;
  - use: instantiated NUM_KEYS times by a generate loop;
  - top level adds only the any_level OR register.

Test Plan (DEBOUNCE_CYCLES=8, REPEAT_DELAY=20, REPEAT_PERIOD=5):
1. Clean press: raw_keys[0] 0->1 at cycle 10 and held -> key_level[0]=1 and key_press[0]=1 at cycle 20 only; any_level=1 at cycle 21.
2. Bounce: raw_keys[3] toggled 1,0,1,0 every 3 cycles, then held 1 -> exactly one key_press[3], 10 cycles after the final rise; no key_release[3].
3. Release glitch: key held, then raw 0 for 4 cycles, back to 1 -> no key_release and key_level stays 1. Then raw 0 held -> one key_release 10 cycles later.
4. Simultaneous: raw_keys[9] and [10] rise on the same cycle -> key_press[9] and [10] pulse on the same cycle, one cycle each.
5. Reset mid-debounce: reset asserted 4 cycles into WAIT_HIGH -> all outputs 0 next cycle, no pulse. With the key still held after reset drops, key_press fires 10 cycles after reset deassertion.
6. KEY_AUTOREPEAT_EN defined, key held 60 cycles after acceptance -> key_press at +0, +20, +25, +30, ... +60. Without the macro -> only the +0 pulse.
